dmem_responder: RTL and testbench

- Responder end of the data SRAM interface driven by the MEM stage.
- Serves every request presented on data_sram_en/wen/addr/wdata, with a fixed 1-cycle read latency.
- Backs a byte-enabled on-chip data RAM and a small MMIO window containing LED, free-running timer and scratch registers.
- Sits at the top level beside the core and replaces an external SRAM model in simulation and FPGA builds.

---
 rtl/dmem_responder_pkg.sv | 28 ++
 rtl/dmem_responder_bram_be.sv | 25 ++
 rtl/dmem_responder.sv | 109 ++++++++++
 tb/tb_dmem_responder.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared constants, read-tag encoding and byte-merge helper for the data-memory responder.
package dmem_responder_pkg;

  localparam logic [31:0] DMEM_MMIO_BASE   = 32'h1FAF_0000;
  localparam logic [15:0] DMEM_LED_OFF     = 16'h0000;
  localparam logic [15:0] DMEM_TIMER_OFF   = 16'h0004;
  localparam logic [15:0] DMEM_SCRATCH_OFF = 16'h0008;
  localparam logic [31:0] DMEM_RDATA_RST   = 32'h0000_0000;

  // Selects which captured source drives rdata in the cycle after a request
  typedef enum logic [1:0] {
    TAG_RAM  = 2'd0,
    TAG_MMIO = 2'd1,
    TAG_ZERO = 2'd2
  } rd_tag_e;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dmem_responder_bram_be.sv
// Single-port read-first RAM with synchronous read and four byte-write enables.
module bram_be #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              en,
  input  logic [3:0]        we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       din,
  output logic [31:0]       dout
);

  logic [31:0] mem [0:(1<<ADDR_W)-1];

  // Output register holds when disabled so the responder can keep rdata stable
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) mem[addr][8*i +: 8] <= din[8*i +: 8];
      end
      dout <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data SRAM responder: byte-enabled RAM plus LED / timer / scratch MMIO window, 1-cycle read latency.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int          ADDR_W    = 12,
  parameter logic [31:0] MMIO_BASE = DMEM_MMIO_BASE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic [15:0] led_out,
  output logic [31:0] timer_out
);

  logic        req;
  logic        is_mmio;
  logic [13:0] mmio_word;
  logic        led_hit;
  logic        timer_hit;
  logic        scratch_hit;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [31:0] ram_q;
  logic [31:0] mmio_rd;
  logic [31:0] mmio_q;
  logic [15:0] led;
  logic [15:0] led_next;
  logic [31:0] timer;
  logic [31:0] scratch;
  rd_tag_e     tag;
  logic        unused_addr_lsb;

  assign unused_addr_lsb = ^data_sram_addr[1:0];

  assign req         = data_sram_en & ~rst;
  assign is_mmio     = (data_sram_addr[31:16] == MMIO_BASE[31:16]);
  assign mmio_word   = data_sram_addr[15:2];
  assign led_hit     = req & is_mmio & (mmio_word == DMEM_LED_OFF[15:2]);
  assign timer_hit   = req & is_mmio & (mmio_word == DMEM_TIMER_OFF[15:2]);
  assign scratch_hit = req & is_mmio & (mmio_word == DMEM_SCRATCH_OFF[15:2]);

  assign ram_en = req & ~is_mmio;
  assign ram_we = ram_en ? data_sram_wen : 4'h0;

  bram_be #(.ADDR_W(ADDR_W)) u_ram (
    .clk  (clk),
    .en   (ram_en),
    .we   (ram_we),
    .addr (data_sram_addr[ADDR_W+1:2]),
    .din  (data_sram_wdata),
    .dout (ram_q)
  );

  always_comb begin
    led_next = led;
    if (data_sram_wen[0]) led_next[7:0]  = data_sram_wdata[7:0];
    if (data_sram_wen[1]) led_next[15:8] = data_sram_wdata[15:8];
  end

  always_comb begin
    mmio_rd = 32'h0;
    if (mmio_word == DMEM_LED_OFF[15:2])          mmio_rd = {16'h0, led};
    else if (mmio_word == DMEM_TIMER_OFF[15:2])   mmio_rd = timer;
    else if (mmio_word == DMEM_SCRATCH_OFF[15:2]) mmio_rd = scratch;
  end

  // A timer write replaces that cycle's increment; counting resumes next cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      led     <= 16'h0;
      timer   <= 32'h0;
      scratch <= 32'h0;
    end else begin
      if (led_hit) led <= led_next;
      if (scratch_hit) scratch <= merge_bytes(scratch, data_sram_wdata, data_sram_wen);
      if (timer_hit && (data_sram_wen != 4'h0))
        timer <= merge_bytes(timer, data_sram_wdata, data_sram_wen);
      else
        timer <= timer + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag    <= TAG_ZERO;
      mmio_q <= DMEM_RDATA_RST;
    end else if (data_sram_en) begin
      tag <= is_mmio ? TAG_MMIO : TAG_RAM;
      if (is_mmio) mmio_q <= mmio_rd;
    end
  end

  always_comb begin
    data_sram_rdata = DMEM_RDATA_RST;
    case (tag)
      TAG_RAM:  data_sram_rdata = ram_q;
      TAG_MMIO: data_sram_rdata = mmio_q;
      default:  data_sram_rdata = DMEM_RDATA_RST;
    endcase
  end

  assign led_out   = led;
  assign timer_out = timer;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a behavioural model queues expected rdata per request.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        data_sram_en = 1'b0;
  logic [3:0]  data_sram_wen = 4'h0;
  logic [31:0] data_sram_addr = 32'h0;
  logic [31:0] data_sram_wdata = 32'h0;
  logic [31:0] data_sram_rdata;
  logic [15:0] led_out;
  logic [31:0] timer_out;

  logic [31:0] ram_m [int];
  logic [15:0] led_m = 16'h0;
  logic [31:0] timer_m = 32'h0;
  logic [31:0] scratch_m = 32'h0;
  logic [31:0] exp_q [$];
  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_W(12), .MMIO_BASE(32'h1FAF_0000)) dut (
    .clk             (clk),
    .rst             (rst),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .led_out         (led_out),
    .timer_out       (timer_out)
  );

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  // Drives one cycle, updates the model and queues the expected rdata for any accepted request
  task automatic drive_cycle(input logic e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] rd;
    logic [31:0] tnext;
    logic [31:0] tmp;
    int idx;
    data_sram_en = e; data_sram_wen = w; data_sram_addr = a; data_sram_wdata = d;
    idx = int'(a[13:2]);
    if (rst) begin
      exp_q.delete();
      led_m = 16'h0; timer_m = 32'h0; scratch_m = 32'h0;
    end else begin
      tnext = timer_m + 32'd1;
      if (e) begin
        rd = 32'h0;
        if (a[31:16] == 16'h1FAF) begin
          case (a[15:2])
            14'd0: begin
              rd = {16'h0, led_m};
              tmp = merge({16'h0, led_m}, d, {2'b00, w[1:0]});
              led_m = tmp[15:0];
            end
            14'd1: begin
              rd = timer_m;
              if (w != 4'h0) tnext = merge(timer_m, d, w);
            end
            14'd2: begin
              rd = scratch_m;
              scratch_m = merge(scratch_m, d, w);
            end
            default: rd = 32'h0;
          endcase
        end else begin
          rd = ram_m.exists(idx) ? ram_m[idx] : 32'h0;
          ram_m[idx] = merge(rd, d, w);
        end
        exp_q.push_back(rd);
      end
      timer_m = tnext;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pop_expected(output logic [31:0] v);
    if (exp_q.size() == 0) v = 32'hxxxx_xxxx;
    else v = exp_q.pop_front();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive_cycle(1'b1, 4'hF, 32'h100, 32'hDEAD_BEEF);
    drive_cycle(1'b1, 4'hF, 32'h100, 32'hDEAD_BEEF);
    n_checks++;
    if (data_sram_rdata !== 32'h0) $display("[TB] FAIL reset_rdata: got %h expected %h", data_sram_rdata, 32'h0);
    else n_pass++;
    n_checks++;
    if (led_out !== 16'h0) $display("[TB] FAIL reset_led: got %h expected %h", led_out, 16'h0);
    else n_pass++;
    n_checks++;
    if (timer_out !== 32'h0) $display("[TB] FAIL reset_timer: got %h expected %h", timer_out, 32'h0);
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_reset_blocks_write;
    logic [31:0] exp;
    drive_cycle(1'b1, 4'hF, 32'h100, 32'h1357_9BDF);
    pop_expected(exp);
    drive_cycle(1'b1, 4'h0, 32'h100, 32'h0);
    pop_expected(exp);
    n_checks++;
    if (data_sram_rdata !== exp) $display("[TB] FAIL ram_write_read: got %h expected %h", data_sram_rdata, exp);
    else n_pass++;
    drive_cycle(1'b1, 4'h0, 32'h100, 32'h0);
    rst = 1'b1;
    drive_cycle(1'b1, 4'hF, 32'h100, 32'hDEAD_BEEF);
    n_checks++;
    if (data_sram_rdata !== 32'h0) $display("[TB] FAIL midstream_reset_rdata: got %h expected %h", data_sram_rdata, 32'h0);
    else n_pass++;
    drive_cycle(1'b1, 4'hF, 32'h100, 32'hDEAD_BEEF);
    rst = 1'b0;
    drive_cycle(1'b1, 4'h0, 32'h100, 32'h0);
    pop_expected(exp);
    n_checks++;
    if (data_sram_rdata !== exp) $display("[TB] FAIL reset_no_write: got %h expected %h", data_sram_rdata, exp);
    else n_pass++;
  endtask

  task automatic test_byte_lanes;
    logic [31:0] exp;
    drive_cycle(1'b1, 4'hF, 32'h40, 32'hAABB_CCDD);
    pop_expected(exp);
    drive_cycle(1'b1, 4'b0010, 32'h41, 32'h0000_1100);
    pop_expected(exp);
    n_checks++;
    if (data_sram_rdata !== exp) $display("[TB] FAIL read_first: got %h expected %h", data_sram_rdata, exp);
    else n_pass++;
    drive_cycle(1'b1, 4'h0, 32'h40, 32'h0);
    pop_expected(exp);
    n_checks++;
    if (data_sram_rdata !== exp) $display("[TB] FAIL byte_lane_merge: got %h expected %h", data_sram_rdata, exp);
    else n_pass++;
  endtask

  task automatic test_latency_hold;
    logic [31:0] exp;
    drive_cycle(1'b1, 4'h0, 32'h40, 32'h0);
    pop_expected(exp);
    n_checks++;
    if (data_sram_rdata !== exp) $display("[TB] FAIL hold_first: got %h expected %h", data_sram_rdata, exp);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b0, 4'hF, 32'h40, 32'hFFFF_FFFF);
      n_checks++;
      if (data_sram_rdata !== exp) $display("[TB] FAIL hold_cycle%0d: got %h expected %h", i, data_sram_rdata, exp);
      else n_pass++;
    end
    drive_cycle(1'b1, 4'h0, 32'h40, 32'h0);
    pop_expected(exp);
    n_checks++;
    if (data_sram_rdata !== exp) $display("[TB] FAIL en_low_no_write: got %h expected %h", data_sram_rdata, exp);
    else n_pass++;
  endtask

  task automatic test_timer;
    logic [31:0] exp;
    rst = 1'b1;
    drive_cycle(1'b0, 4'h0, 32'h0, 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) drive_cycle(1'b0, 4'h0, 32'h0, 32'h0);
    drive_cycle(1'b1, 4'h0, 32'h1FAF_0004, 32'h0);
    pop_expected(exp);
    n_checks++;
    if (data_sram_rdata !== exp) $display("[TB] FAIL timer_read: got %h expected %h", data_sram_rdata, exp);
    else n_pass++;
    drive_cycle(1'b1, 4'hF, 32'h1FAF_0004, 32'hFFFF_FFFE);
    pop_expected(exp);
    n_checks++;
    if (data_sram_rdata !== exp) $display("[TB] FAIL timer_write_rdata: got %h expected %h", data_sram_rdata, exp);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (timer_out !== timer_m) $display("[TB] FAIL timer_wrap%0d: got %h expected %h", i, timer_out, timer_m);
      else n_pass++;
      drive_cycle(1'b0, 4'h0, 32'h0, 32'h0);
    end
    drive_cycle(1'b1, 4'b0001, 32'h1FAF_0005, 32'h0000_00AB);
    pop_expected(exp);
    n_checks++;
    if (timer_out !== timer_m) $display("[TB] FAIL timer_lane_write: got %h expected %h", timer_out, timer_m);
    else n_pass++;
  endtask

  task automatic test_led_unmapped;
    logic [31:0] exp;
    drive_cycle(1'b1, 4'hF, 32'h1FAF_0000, 32'hDEAD_1234);
    pop_expected(exp);
    n_checks++;
    if (led_out !== led_m) $display("[TB] FAIL led_write: got %h expected %h", led_out, led_m);
    else n_pass++;
    drive_cycle(1'b1, 4'h0, 32'h1FAF_0000, 32'h0);
    pop_expected(exp);
    n_checks++;
    if (data_sram_rdata !== exp) $display("[TB] FAIL led_read: got %h expected %h", data_sram_rdata, exp);
    else n_pass++;
    drive_cycle(1'b1, 4'b0101, 32'h1FAF_0008, 32'h1122_3344);
    pop_expected(exp);
    drive_cycle(1'b1, 4'hF, 32'h1FAF_0010, 32'hFFFF_FFFF);
    pop_expected(exp);
    n_checks++;
    if (data_sram_rdata !== exp) $display("[TB] FAIL unmapped_write_rdata: got %h expected %h", data_sram_rdata, exp);
    else n_pass++;
    drive_cycle(1'b1, 4'h0, 32'h1FAF_0010, 32'h0);
    pop_expected(exp);
    n_checks++;
    if (data_sram_rdata !== exp) $display("[TB] FAIL unmapped_read: got %h expected %h", data_sram_rdata, exp);
    else n_pass++;
    n_checks++;
    if (led_out !== led_m) $display("[TB] FAIL led_unchanged: got %h expected %h", led_out, led_m);
    else n_pass++;
    drive_cycle(1'b1, 4'h0, 32'h1FAF_0008, 32'h0);
    pop_expected(exp);
    n_checks++;
    if (data_sram_rdata !== exp) $display("[TB] FAIL scratch_read: got %h expected %h", data_sram_rdata, exp);
    else n_pass++;
  endtask

  task automatic test_alias_decode;
    logic [31:0] exp;
    drive_cycle(1'b1, 4'hF, 32'h0000_0010, 32'h5A5A_5A5A);
    pop_expected(exp);
    drive_cycle(1'b1, 4'h0, 32'h0001_0010, 32'h0);
    pop_expected(exp);
    n_checks++;
    if (data_sram_rdata !== exp) $display("[TB] FAIL ram_alias: got %h expected %h", data_sram_rdata, exp);
    else n_pass++;
    drive_cycle(1'b1, 4'hF, 32'h0000_0008, 32'hCAFE_F00D);
    pop_expected(exp);
    rst = 1'b1;
    drive_cycle(1'b0, 4'h0, 32'h0, 32'h0);
    rst = 1'b0;
    drive_cycle(1'b1, 4'h0, 32'h1FAF_0008, 32'h0);
    pop_expected(exp);
    n_checks++;
    if (data_sram_rdata !== exp) $display("[TB] FAIL mmio_not_ram: got %h expected %h", data_sram_rdata, exp);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp;
    drive_cycle(1'b1, 4'hF, 32'h80, 32'h1234_5678);
    pop_expected(exp);
    drive_cycle(1'b1, 4'h0, 32'h80, 32'h0);
    pop_expected(exp);
    n_checks++;
    if (data_sram_rdata !== exp) $display("[TB] FAIL write_then_read: got %h expected %h", data_sram_rdata, exp);
    else n_pass++;
    drive_cycle(1'b1, 4'hF, 32'h1FAF_0008, 32'h0BAD_CAFE);
    pop_expected(exp);
    drive_cycle(1'b1, 4'h0, 32'h1FAF_0008, 32'h0);
    pop_expected(exp);
    n_checks++;
    if (data_sram_rdata !== exp) $display("[TB] FAIL mmio_then_ram_a: got %h expected %h", data_sram_rdata, exp);
    else n_pass++;
    drive_cycle(1'b1, 4'h0, 32'h80, 32'h0);
    pop_expected(exp);
    n_checks++;
    if (data_sram_rdata !== exp) $display("[TB] FAIL mmio_then_ram_b: got %h expected %h", data_sram_rdata, exp);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_reset_blocks_write();
    test_byte_lanes();
    test_latency_hold();
    test_timer();
    test_led_unmapped();
    test_alias_decode();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got no completion expected finish before 200000");
    $fatal(1, "[TB] timeout");
  end

endmodule
